// File: rtl/pes_sensor_conditioner_pkg.sv
// Shared types and constants for the farm-road loop-detector conditioner.
// State encodings and default timing match those used by traffic_light.
package pes_sensor_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_PRESENT = 3'd2,
    ST_RELEASE = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  localparam int DEF_ON_CYCLES    = 8;
  localparam int DEF_OFF_CYCLES   = 16;
  localparam int DEF_MIN_HOLD     = 32;
  localparam int DEF_STUCK_CYCLES = 4096;
  localparam int DEF_CNT_W        = 8;

  // Timers stick at all-ones rather than wrapping back to zero.
  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + TMR_ONE;
  endfunction

  function automatic logic drives_sensor(input state_e s);
    return (s == ST_PRESENT) || (s == ST_RELEASE) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/pes_sensor_conditioner_sync2.sv
// Two-flop synchroniser for the asynchronous loop detector input.
// Both stages clear to 0 under synchronous active-low reset.
module pes_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pes_sensor_conditioner.sv
// Debounces the farm-road loop into a minimum-hold 'sensor' level, flags a
// stuck-on loop (forcing sensor high) and counts qualified arrivals.
//
//  state   | meaning
//  IDLE    | road clear, waiting for a synced-high sample
//  ARM     | loop high, counting toward a qualified vehicle
//  PRESENT | vehicle declared, minimum hold running
//  RELEASE | loop low after hold, counting toward road clear
//  FAULT   | loop stuck high, sensor forced on until loop stays low
module pes_sensor_conditioner
  import pes_sensor_conditioner_pkg::*;
#(
  parameter int ON_CYCLES    = DEF_ON_CYCLES,
  parameter int OFF_CYCLES   = DEF_OFF_CYCLES,
  parameter int MIN_HOLD     = DEF_MIN_HOLD,
  parameter int STUCK_CYCLES = DEF_STUCK_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic             clr_count,
  output logic             sensor,
  output logic             arrive_pulse,
  output logic [CNT_W-1:0] car_count,
  output logic             stuck_fault
);

  localparam logic [TMR_W-1:0] ON_C    = TMR_W'(ON_CYCLES);
  localparam logic [TMR_W-1:0] OFF_C   = TMR_W'(OFF_CYCLES);
  localparam logic [TMR_W-1:0] HOLD_C  = TMR_W'(MIN_HOLD);
  localparam logic [TMR_W-1:0] STUCK_C = TMR_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic loop_s;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] on_tmr_q, on_tmr_d;
  logic [TMR_W-1:0] off_tmr_q, off_tmr_d;
  logic [TMR_W-1:0] hold_tmr_q, hold_tmr_d;
  logic [TMR_W-1:0] hi_tmr_q, hi_tmr_d;
  logic             sensor_q, sensor_d;
  logic             arrive_q, arrive_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [TMR_W-1:0] on_inc, off_inc, hi_inc;
  logic             stuck_hit;

  pes_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (loop_raw),
    .q     (loop_s)
  );

  always_comb begin
    on_inc  = sat_inc(on_tmr_q);
    off_inc = sat_inc(off_tmr_q);
    hi_inc  = sat_inc(hi_tmr_q);

    state_d    = state_q;
    on_tmr_d   = on_tmr_q;
    off_tmr_d  = off_tmr_q;
    hold_tmr_d = hold_tmr_q;
    hi_tmr_d   = loop_s ? hi_inc : '0;

    // Stuck detection overrides whatever the normal state logic would do.
    stuck_hit = (state_q != ST_FAULT) && loop_s && (hi_inc >= STUCK_C);

    if (stuck_hit) begin
      state_d   = ST_FAULT;
      off_tmr_d = '0;
      hi_tmr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (loop_s) begin
            state_d  = ST_ARM;
            on_tmr_d = TMR_ONE;
          end
        end
        ST_ARM: begin
          if (!loop_s) begin
            state_d  = ST_IDLE;
            on_tmr_d = '0;
          end else begin
            on_tmr_d = on_inc;
            if (on_inc >= ON_C) begin
              state_d    = ST_PRESENT;
              hold_tmr_d = '0;
            end
          end
        end
        ST_PRESENT: begin
          if (hold_tmr_q < HOLD_C) hold_tmr_d = sat_inc(hold_tmr_q);
          if (!loop_s && (hold_tmr_q >= HOLD_C)) begin
            state_d   = ST_RELEASE;
            off_tmr_d = TMR_ONE;
          end
        end
        ST_RELEASE: begin
          // A return of the loop here is the same vehicle: hold stays satisfied.
          if (loop_s) begin
            state_d = ST_PRESENT;
          end else begin
            off_tmr_d = off_inc;
            if (off_inc >= OFF_C) state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          hi_tmr_d = '0;
          if (loop_s) begin
            off_tmr_d = '0;
          end else begin
            off_tmr_d = off_inc;
            if (off_inc >= OFF_C) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    sensor_d = drives_sensor(state_d);
    fault_d  = (state_d == ST_FAULT);
    arrive_d = (state_q == ST_ARM) && (state_d == ST_PRESENT);

    // Clear wins over a same-cycle arrival.
    if (clr_count)
      count_d = '0;
    else if (arrive_d && (count_q != CNT_MAX))
      count_d = count_q + CNT_ONE;
    else
      count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      on_tmr_q   <= '0;
      off_tmr_q  <= '0;
      hold_tmr_q <= '0;
      hi_tmr_q   <= '0;
      sensor_q   <= 1'b0;
      arrive_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      on_tmr_q   <= on_tmr_d;
      off_tmr_q  <= off_tmr_d;
      hold_tmr_q <= hold_tmr_d;
      hi_tmr_q   <= hi_tmr_d;
      sensor_q   <= sensor_d;
      arrive_q   <= arrive_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign sensor       = sensor_q;
  assign arrive_pulse = arrive_q;
  assign stuck_fault  = fault_q;
  assign car_count    = count_q;

endmodule

// File: tb/tb_pes_sensor_conditioner.sv
// Bench for pes_sensor_conditioner: a default-parameter instance plus a small
// instance (ON=1, OFF=3, HOLD=4, STUCK=64, CNT_W=2), both against a run-length model.
module tb_pes_sensor_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, loop_raw, clr_count, loop_raw2, clr_count2;
  logic       sensor, arrive_pulse, stuck_fault;
  logic [7:0] car_count;
  logic       sensor2, arrive_pulse2, stuck_fault2;
  logic [1:0] car_count2;

  int n_total = 0;
  int n_pass  = 0;

  pes_sensor_conditioner dut (
    .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw), .clr_count(clr_count),
    .sensor(sensor), .arrive_pulse(arrive_pulse), .car_count(car_count),
    .stuck_fault(stuck_fault)
  );

  pes_sensor_conditioner #(
    .ON_CYCLES(1), .OFF_CYCLES(3), .MIN_HOLD(4), .STUCK_CYCLES(64), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .loop_raw(loop_raw2), .clr_count(clr_count2),
    .sensor(sensor2), .arrive_pulse(arrive_pulse2), .car_count(car_count2),
    .stuck_fault(stuck_fault2)
  );

  // Model state, index 0 = dut, 1 = dut2. Behaviour is expressed with run lengths
  // of the synchronised loop and the age of the current assertion.
  int p_on[2]     = '{8, 1};
  int p_off[2]    = '{16, 3};
  int p_hold[2]   = '{32, 4};
  int p_stuck[2]  = '{4096, 64};
  int p_cntmax[2] = '{255, 3};
  bit m_s1[2], m_s2[2], m_present[2], m_fault[2], m_arr[2];
  int m_hi[2], m_lo[2], m_age[2], m_cnt[2];

  task automatic model_step(input int k, input logic raw, input logic clr);
    bit ls;
    int need_on, need_off, elig;
    if (!rst_n) begin
      m_s1[k] = 0; m_s2[k] = 0; m_present[k] = 0; m_fault[k] = 0; m_arr[k] = 0;
      m_hi[k] = 0; m_lo[k] = 0; m_age[k] = 0; m_cnt[k] = 0;
      return;
    end
    ls = m_s2[k];
    m_s2[k] = m_s1[k];
    m_s1[k] = raw;
    if (ls) begin m_hi[k]++; m_lo[k] = 0; end
    else    begin m_lo[k]++; m_hi[k] = 0; end
    need_on  = (p_on[k]  < 2) ? 2 : p_on[k];
    need_off = (p_off[k] < 2) ? 2 : p_off[k];
    m_arr[k] = 0;
    if (m_fault[k]) begin
      if (m_lo[k] >= p_off[k]) m_fault[k] = 0;
    end else if (m_hi[k] >= p_stuck[k]) begin
      m_fault[k] = 1;
      m_present[k] = 0;
    end else if (m_present[k]) begin
      m_age[k]++;
      elig = (m_lo[k] < m_age[k] - p_hold[k]) ? m_lo[k] : m_age[k] - p_hold[k];
      if (elig >= need_off) m_present[k] = 0;
    end else if (m_hi[k] == need_on) begin
      m_present[k] = 1;
      m_age[k] = 0;
      m_arr[k] = 1;
    end
    if (clr) m_cnt[k] = 0;
    else if (m_arr[k] && m_cnt[k] < p_cntmax[k]) m_cnt[k]++;
  endtask

  function automatic logic [10:0] exp0();
    return {m_present[0] | m_fault[0], m_arr[0], m_fault[0], 8'(m_cnt[0])};
  endfunction

  function automatic logic [4:0] exp1();
    return {m_present[1] | m_fault[1], m_arr[1], m_fault[1], 2'(m_cnt[1])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, loop_raw, clr_count);
    model_step(1, loop_raw2, clr_count2);
    #1;
  endtask

  task automatic test_reset();
    int rise = -1;
    rst_n = 0; loop_raw = 1; loop_raw2 = 1; clr_count = 0; clr_count2 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== 11'd0 ||
          {sensor2, arrive_pulse2, stuck_fault2, car_count2} !== 5'd0)
        $display("FAIL reset_outputs cycle=%0d actual=%b/%b required=0", i,
                 {sensor, arrive_pulse, stuck_fault, car_count},
                 {sensor2, arrive_pulse2, stuck_fault2, car_count2});
      else n_pass++;
    end
    rst_n = 1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL reset_model edge=%0d actual=%b required=%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
      else n_pass++;
      if (sensor && rise < 0) rise = e;
    end
    n_total++;
    if (rise !== 10) $display("FAIL reset_release_rise actual=%0d required=10", rise);
    else n_pass++;
    loop_raw = 0; loop_raw2 = 0;
    for (int e = 1; e <= 80; e++) begin
      tick();
      n_total++;
      if ({sensor2, arrive_pulse2, stuck_fault2, car_count2} !== exp1() ||
          {sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL reset_drain edge=%0d actual=%b/%b required=%b/%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count},
                 {sensor2, arrive_pulse2, stuck_fault2, car_count2}, exp0(), exp1());
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int sens_seen = 0, arrivals = 0;
    clr_count = 1; tick(); clr_count = 0;
    for (int e = 1; e <= 35; e++) begin
      loop_raw = (e <= 5);
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL glitch_model edge=%0d actual=%b required=%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
      else n_pass++;
      sens_seen += int'(sensor);
      arrivals  += int'(arrive_pulse);
    end
    n_total++;
    if (sens_seen != 0 || arrivals != 0 || car_count !== 8'd0)
      $display("FAIL glitch_reject actual=sensor%0d/arrive%0d/count%0d required=0/0/0",
               sens_seen, arrivals, car_count);
    else n_pass++;
  endtask

  task automatic test_clean_car();
    int rise = -1, fall = -1, arrivals = 0;
    clr_count = 1; tick(); clr_count = 0;
    loop_raw = 1;
    for (int e = 1; e <= 90; e++) begin
      if (e == 51) loop_raw = 0;
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL clean_model edge=%0d actual=%b required=%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
      else n_pass++;
      if (sensor && rise < 0) rise = e;
      if (!sensor && rise > 0 && fall < 0) fall = e - 50;
      arrivals += int'(arrive_pulse);
    end
    n_total++;
    if (rise != 10 || fall != 18 || arrivals != 1 || car_count !== 8'd1)
      $display("FAIL clean_timing actual=rise%0d/fall%0d/arr%0d/cnt%0d required=10/18/1/1",
               rise, fall, arrivals, car_count);
    else n_pass++;
  endtask

  task automatic test_hold_bounce();
    int seg_len[4] = '{12, 3, 2, 60};
    int e = 0, rise = -1, fall = -1, arrivals = 0;
    clr_count = 1; tick(); clr_count = 0;
    for (int s = 0; s < 4; s++) begin
      loop_raw = (s % 2 == 0);
      for (int i = 0; i < seg_len[s]; i++) begin
        e++;
        tick();
        n_total++;
        if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
          $display("FAIL bounce_model edge=%0d actual=%b required=%b", e,
                   {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
        else n_pass++;
        if (sensor && rise < 0) rise = e;
        if (!sensor && rise > 0 && fall < 0) fall = e;
        arrivals += int'(arrive_pulse);
      end
    end
    n_total++;
    if (rise != 10 || fall != 58 || arrivals != 1)
      $display("FAIL bounce_hold actual=rise%0d/fall%0d/arr%0d required=10/58/1",
               rise, fall, arrivals);
    else n_pass++;
  endtask

  task automatic test_stuck();
    int fault_at = -1, clear_at = -1, arrivals = 0;
    logic sens_at_fault = 1'b0;
    clr_count = 1; tick(); clr_count = 0;
    loop_raw = 1;
    for (int e = 1; e <= 5040; e++) begin
      if (e == 5001) loop_raw = 0;
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL stuck_model edge=%0d actual=%b required=%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
      else n_pass++;
      if (stuck_fault && fault_at < 0) begin fault_at = e; sens_at_fault = sensor; end
      if (!stuck_fault && !sensor && fault_at > 0 && clear_at < 0) clear_at = e - 5000;
      arrivals += int'(arrive_pulse);
    end
    n_total++;
    if (fault_at != 4098 || sens_at_fault !== 1'b1 || clear_at != 18 || arrivals != 1)
      $display("FAIL stuck_detect actual=fault%0d/sens%b/clear%0d/arr%0d required=4098/1/18/1",
               fault_at, sens_at_fault, clear_at, arrivals);
    else n_pass++;
  endtask

  task automatic test_counter();
    int rise = -1;
    clr_count2 = 1; tick(); clr_count2 = 0;
    for (int c = 0; c < 5; c++) begin
      for (int e = 1; e <= 23; e++) begin
        loop_raw2 = (e <= 3);
        tick();
        n_total++;
        if ({sensor2, arrive_pulse2, stuck_fault2, car_count2} !== exp1())
          $display("FAIL counter_model car=%0d edge=%0d actual=%b required=%b", c, e,
                   {sensor2, arrive_pulse2, stuck_fault2, car_count2}, exp1());
        else n_pass++;
        if (c == 0 && sensor2 && rise < 0) rise = e;
      end
    end
    n_total++;
    if (car_count2 !== 2'd3 || rise != 4)
      $display("FAIL counter_saturate actual=cnt%0d/rise%0d required=3/4", car_count2, rise);
    else n_pass++;
    loop_raw2 = 1;
    tick(); tick(); tick();
    clr_count2 = 1;
    tick();
    clr_count2 = 0;
    n_total++;
    if (arrive_pulse2 !== 1'b1 || car_count2 !== 2'd0)
      $display("FAIL counter_clr_vs_arrival actual=arr%b/cnt%0d required=1/0",
               arrive_pulse2, car_count2);
    else n_pass++;
    for (int e = 1; e <= 40; e++) begin
      loop_raw2 = (e >= 20 && e <= 22);
      tick();
      n_total++;
      if ({sensor2, arrive_pulse2, stuck_fault2, car_count2} !== exp1())
        $display("FAIL counter_after_clr edge=%0d actual=%b required=%b", e,
                 {sensor2, arrive_pulse2, stuck_fault2, car_count2}, exp1());
      else n_pass++;
    end
    n_total++;
    if (car_count2 !== 2'd1) $display("FAIL counter_recount actual=%0d required=1", car_count2);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    loop_raw = 1; loop_raw2 = 1;
    for (int e = 1; e <= 15; e++) tick();
    rst_n = 0;
    tick();
    n_total++;
    if ({sensor, arrive_pulse, stuck_fault, car_count} !== 11'd0 ||
        {sensor2, arrive_pulse2, stuck_fault2, car_count2} !== 5'd0)
      $display("FAIL mid_reset actual=%b/%b required=0",
               {sensor, arrive_pulse, stuck_fault, car_count},
               {sensor2, arrive_pulse2, stuck_fault2, car_count2});
    else n_pass++;
    rst_n = 1; loop_raw = 0; loop_raw2 = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0() ||
          {sensor2, arrive_pulse2, stuck_fault2, car_count2} !== exp1())
        $display("FAIL mid_reset_after edge=%0d actual=%b/%b required=%b/%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count},
                 {sensor2, arrive_pulse2, stuck_fault2, car_count2}, exp0(), exp1());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int run0 = 0, run1 = 0;
    for (int e = 1; e <= 4000; e++) begin
      #($urandom_range(0, 7));
      if (run0 == 0) begin loop_raw = ~loop_raw; run0 = $urandom_range(1, 70); end
      if (run1 == 0) begin loop_raw2 = ~loop_raw2; run1 = $urandom_range(1, 90); end
      run0--; run1--;
      clr_count  = ($urandom_range(0, 63) == 0);
      clr_count2 = ($urandom_range(0, 63) == 0);
      tick();
      n_total++;
      if ({sensor, arrive_pulse, stuck_fault, car_count} !== exp0())
        $display("FAIL random_dut edge=%0d actual=%b required=%b", e,
                 {sensor, arrive_pulse, stuck_fault, car_count}, exp0());
      else n_pass++;
      n_total++;
      if ({sensor2, arrive_pulse2, stuck_fault2, car_count2} !== exp1())
        $display("FAIL random_dut2 edge=%0d actual=%b required=%b", e,
                 {sensor2, arrive_pulse2, stuck_fault2, car_count2}, exp1());
      else n_pass++;
    end
    clr_count = 0; clr_count2 = 0;
  endtask

  initial begin
    rst_n = 0; loop_raw = 0; loop_raw2 = 0; clr_count = 0; clr_count2 = 0;
    test_reset();
    test_glitch();
    test_clean_car();
    test_hold_bounce();
    test_stuck();
    test_counter();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
